// File: rtl/fft_pkg.sv
// Shared widths, FSM encoding and magnitude helpers for the spectrum transmitter.
package fft_pkg;

    localparam int IN_W  = 16;
    localparam int MAG_W = 16;

    // Magnitude ceiling held in the 17-bit intermediate width.
    localparam logic [MAG_W:0]   MAG_SAT = 17'd65535;
    localparam logic [MAG_W-1:0] ABS_SAT = 16'd32767;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // |x| with the most negative code clamped so the result fits in 15 bits.
    function automatic logic [MAG_W-1:0] abs_sat(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] neg;
        neg = ~x + IN_W'(1);
        if (!x[IN_W-1]) begin
            return MAG_W'(x);
        end else if (x == {1'b1, {(IN_W-1){1'b0}}}) begin
            return ABS_SAT;
        end else begin
            return MAG_W'(neg);
        end
    endfunction

    // max + min/2 approximation of sqrt(a^2 + b^2).
    function automatic logic [MAG_W-1:0] mag_calc(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        logic [MAG_W-1:0] mx;
        logic [MAG_W-1:0] mn;
        logic [MAG_W:0]   sum;
        mx  = (a > b) ? a : b;
        mn  = (a > b) ? b : a;
        sum = {1'b0, mx} + {2'b00, mn[MAG_W-1:1]};
        if (sum > MAG_SAT) begin
            return MAG_SAT[MAG_W-1:0];
        end
        return sum[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/fft_spectrum_tx_if.sv
// Input FFT stream, output spectrum stream and status of the spectrum transmitter.
interface fft_spectrum_tx_if;
    import fft_pkg::*;

    logic signed [IN_W-1:0] in_re;
    logic signed [IN_W-1:0] in_im;
    logic                   in_valid;
    logic                   in_sop;
    logic                   in_eop;

    logic [MAG_W-1:0]       fft_data;
    logic                   fft_sop;
    logic                   fft_eop;
    logic                   fft_valid;
    logic                   busy;
    logic [7:0]             err_cnt;

    modport master (
        output in_re, in_im, in_valid, in_sop, in_eop,
        input  fft_data, fft_sop, fft_eop, fft_valid, busy, err_cnt
    );

    modport slave (
        input  in_re, in_im, in_valid, in_sop, in_eop,
        output fft_data, fft_sop, fft_eop, fft_valid, busy, err_cnt
    );

endinterface

// File: rtl/spec_buf_ram.sv
// Simple dual-port spectrum buffer: one write port, one registered read port, one clock.
module spec_buf_ram #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fft_spectrum_tx.sv
// Captures the magnitude of the first N_OUT bins of every FRAME_DIV-th good FFT
// frame and replays them as a contiguous sop/eop-framed output burst.
module fft_spectrum_tx
    import fft_pkg::*;
#(
    parameter int N_FFT     = 256,
    parameter int N_OUT     = 128,
    parameter int FRAME_DIV = 4
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    fft_spectrum_tx_if.slave  bus
);

    localparam int K_W = $clog2(N_FFT);
    localparam int A_W = $clog2(N_OUT);
    localparam int F_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int S_W = $clog2(N_OUT + 3);

    localparam logic [K_W-1:0] K_LAST     = K_W'(N_FFT - 1);
    localparam logic [K_W:0]   K_NOUT     = (K_W + 1)'(N_OUT);
    localparam logic [A_W-1:0] A_LAST     = A_W'(N_OUT - 1);
    localparam logic [F_W-1:0] F_LAST     = F_W'(FRAME_DIV - 1);
    localparam logic [S_W-1:0] S_RD_FIRST = S_W'(2);
    localparam logic [S_W-1:0] S_RD_END   = S_W'(N_OUT + 2);

    state_t           state_reg, state_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [F_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [S_W-1:0]   send_cnt_reg, send_cnt_next;
    logic [7:0]       err_cnt_reg;

    logic             accept;
    logic             restart;
    logic             err_inc;
    logic [K_W-1:0]   pt_idx;
    logic             pt_wr;
    logic             rd_req;
    logic [A_W-1:0]   rd_addr;

    logic             s1_vld_reg;
    logic [A_W-1:0]   s1_addr_reg;
    logic [MAG_W-1:0] s1_a_reg;
    logic [MAG_W-1:0] s1_b_reg;
    logic             s2_vld_reg;
    logic [A_W-1:0]   s2_addr_reg;
    logic [MAG_W-1:0] s2_mag_reg;

    logic             rd_vld_reg;
    logic [A_W-1:0]   rd_addr_reg;
    logic [MAG_W-1:0] ram_rdata;

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        frame_cnt_next = frame_cnt_reg;
        send_cnt_next  = send_cnt_reg;
        accept         = 1'b0;
        restart        = 1'b0;
        err_inc        = 1'b0;
        pt_idx         = '0;
        pt_wr          = 1'b0;
        rd_req         = 1'b0;
        rd_addr        = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid && bus.in_sop) begin
                    accept = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (bus.in_sop) begin
                        restart = 1'b1;
                    end else begin
                        pt_idx = k_reg + K_W'(1);
                    end
                end
            end
            ST_SEND: begin
                // Two drain cycles, then one read per cycle; leave with the last output.
                send_cnt_next = send_cnt_reg + S_W'(1);
                if (send_cnt_reg >= S_RD_FIRST && send_cnt_reg < S_RD_END) begin
                    rd_req  = 1'b1;
                    rd_addr = A_W'(send_cnt_reg - S_RD_FIRST);
                end
                if (rd_vld_reg && rd_addr_reg == A_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept) begin
            k_next     = pt_idx;
            pt_wr      = ({1'b0, pt_idx} < K_NOUT);
            state_next = ST_CAPTURE;
            if (restart) begin
                err_inc = 1'b1;
                if (bus.in_eop) begin
                    state_next = ST_IDLE;
                end
            end else if (pt_idx == K_LAST) begin
                if (bus.in_eop) begin
                    frame_cnt_next = (frame_cnt_reg == F_LAST) ? '0 : frame_cnt_reg + F_W'(1);
                    state_next     = (frame_cnt_reg == '0) ? ST_SEND : ST_IDLE;
                    send_cnt_next  = '0;
                end else begin
                    err_inc    = 1'b1;
                    state_next = ST_IDLE;
                end
            end else if (bus.in_eop) begin
                err_inc    = 1'b1;
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            frame_cnt_reg <= '0;
            send_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            s1_vld_reg    <= 1'b0;
            s1_addr_reg   <= '0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s2_vld_reg    <= 1'b0;
            s2_addr_reg   <= '0;
            s2_mag_reg    <= '0;
            rd_vld_reg    <= 1'b0;
            rd_addr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            frame_cnt_reg <= frame_cnt_next;
            send_cnt_reg  <= send_cnt_next;
            if (err_inc && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            s1_vld_reg    <= pt_wr;
            s1_addr_reg   <= A_W'(pt_idx);
            s1_a_reg      <= abs_sat(bus.in_re);
            s1_b_reg      <= abs_sat(bus.in_im);
            s2_vld_reg    <= s1_vld_reg;
            s2_addr_reg   <= s1_addr_reg;
            s2_mag_reg    <= mag_calc(s1_a_reg, s1_b_reg);
            rd_vld_reg    <= rd_req;
            rd_addr_reg   <= rd_addr;
        end
    end

    spec_buf_ram #(
        .DEPTH (N_OUT),
        .WIDTH (MAG_W),
        .ADDR_W(A_W)
    ) u_buf (
        .clk   (clk_50m),
        .we    (s2_vld_reg),
        .waddr (s2_addr_reg),
        .wdata (s2_mag_reg),
        .re    (rd_req),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // RAM data is not reset, so gate it with the reset-cleared valid.
    assign bus.fft_valid = rd_vld_reg;
    assign bus.fft_data  = rd_vld_reg ? ram_rdata : '0;
    assign bus.fft_sop   = rd_vld_reg && (rd_addr_reg == '0);
    assign bus.fft_eop   = rd_vld_reg && (rd_addr_reg == A_LAST);
    assign bus.busy      = (state_reg == ST_SEND);
    assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: doc/fft_spectrum_tx.md
FFT_SPECTRUM_TX -- requirements
Module: fft_spectrum_tx

Interface
REQ-001 Parameter N_FFT, default 256: number of points in one input FFT frame.
REQ-002 Parameter N_OUT, default 128: number of points transmitted per output frame (bins 0..N_OUT-1).
REQ-003 Parameter FRAME_DIV, default 4: transmit one captured frame in every FRAME_DIV complete frames.
REQ-004 clk_50m  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_re  in  16  signed real part of the FFT core output.
REQ-007 in_im  in  16  signed imaginary part of the FFT core output.
REQ-008 in_valid  in  1  input sample qualifier; no backpressure exists.
REQ-009 in_sop  in  1  first point of an input frame, qualified by in_valid.
REQ-010 in_eop  in  1  last point of an input frame, qualified by in_valid.
REQ-011 fft_data  out  16  unsigned magnitude of a spectrum point.
REQ-012 fft_sop  out  1  first transmitted point of a frame.
REQ-013 fft_eop  out  1  last transmitted point of a frame.
REQ-014 fft_valid  out  1  fft_data, fft_sop and fft_eop are valid.
REQ-015 busy  out  1  high while the block is in the SEND state.
REQ-016 err_cnt  out  8  saturating count of malformed input frames.

Function
REQ-017 The FSM SHALL have three states: IDLE, CAPTURE and SEND.
  - IDLE -> CAPTURE on in_valid & in_sop.
  - CAPTURE -> IDLE or SEND at the end of a good frame.
  - SEND -> IDLE after the N_OUT-th output.
REQ-018 Magnitude SHALL be computed as a = |in_re|, b = |in_im|, mag = max(a,b) + (min(a,b) >> 1), 17-bit internal.
  - |-32768| saturates to 32767.
  - mag is saturated to 65535.
REQ-019 The magnitude pipeline SHALL be 2 registered stages: abs, then mag.
  - The buffer write occurs 2 cycles after the qualifying input.
REQ-020 Point index k SHALL reset to 0 on a qualified sop and increment on each in_valid in CAPTURE.
  - Only points k < N_OUT are written, to buffer address k.
REQ-021 A frame is good when in_eop arrives with k == N_FFT-1.
  - frame_cnt then increments modulo FRAME_DIV.
  - Go to SEND if frame_cnt was 0; otherwise go to IDLE.
REQ-022 A frame is malformed in either case:
  - in_eop arrives with k != N_FFT-1;
  - in_sop arrives in CAPTURE with k != 0.
  Then err_cnt increments (saturating at 255) and frame_cnt is unchanged. For a sop-restart, capture restarts at k = 0; for an early eop, the FSM goes to IDLE.
REQ-023 k reaching N_FFT-1 without in_eop SHALL be malformed; the FSM goes to IDLE.
REQ-024 SEND SHALL wait 2 cycles for the pipeline to drain, then read addresses 0..N_OUT-1, one per cycle.
  - The buffer has a synchronous 1-cycle read.
  - fft_valid is high for exactly N_OUT consecutive cycles.
REQ-025 fft_sop SHALL be high only with point 0 and fft_eop only with point N_OUT-1; both are 0 whenever fft_valid is 0.
REQ-026 Input in SEND SHALL be ignored: no buffer writes, no err_cnt change, no frame_cnt change.
  - A sop arriving in the cycle SEND exits is ignored too; capture resumes at the next sop seen in IDLE.
REQ-027 With FRAME_DIV = 1, every good frame SHALL be transmitted.

Reset
REQ-028 rst_n low SHALL immediately set the following, including mid-SEND (a partial output frame is truncated and no eop is issued):
  - state = IDLE;
  - k = 0, frame_cnt = 0, err_cnt = 0;
  - pipeline valids = 0;
  - fft_data = 0, fft_sop = 0, fft_eop = 0, fft_valid = 0, busy = 0.
REQ-029 Buffer contents SHALL be undefined after reset and never read before a good capture.

Structure
REQ-030 A shared package fft_pkg SHALL hold:
  - MAG_W = 16 and IN_W = 16;
  - the FSM state encoding;
  - the magnitude saturation constant.
REQ-031 The buffer SHALL be a sub-module spec_buf_ram: simple dual-port, N_OUT x 16, synchronous read, single clock.

Verification
REQ-032 Ramp test: a 256-point frame with in_re = k, in_im = 0, FRAME_DIV = 1 -> 128 outputs 0..127, sop on 0, eop on 127, valid contiguous.
REQ-033 Saturation test: in_re = -32768, in_im = -32768 -> fft_data = 49150; in_re = 32767, in_im = 32767 -> 49150; in_re = 3, in_im = -4 -> 5.
REQ-034 Decimation test: 8 good frames with FRAME_DIV = 4 -> exactly 2 output frames, after input frames 1 and 5.
REQ-035 Malformed-frame test: eop at k = 100, then sop at k = 50, then a good frame -> err_cnt = 2 and one output frame from the good frame only.
REQ-036 Busy test: sop arrives during SEND -> frame ignored, err_cnt unchanged, outputs unaffected.
REQ-037 Reset test: rst_n low at output point 60 -> all outputs 0 within the same cycle; a subsequent good frame transmits normally.
